// File: rtl/dbus_responder.sv
// ============================================================================
// dbus_responder : single-outstanding data-bus slave over a word-addressed RAM
// Optional DBUS_RESPONDER_RANDOM_DELAY_EN adds 0..3 LFSR-driven extra cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;
endpackage

module dbus_responder
   import dbus_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       misaligned
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   msize_t      size_q, size_d;
   logic [3:0]  strb_q, strb_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] idx;
   logic [1:0]            extra;
   logic [4:0]            lat_tot;
   logic                  misal;
   logic                  we;
   logic                  unused_addr_hi;

   assign idx            = addr_q[DEPTH_LOG2+1:2];
   assign unused_addr_hi = ^addr_q[31:DEPTH_LOG2+2];

`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign extra = lfsr_q[1:0];
`else
   assign extra = 2'd0;
`endif

   // Total wait beyond the minimum; zero means straight to RESP
   assign lat_tot = 5'(LATENCY) + {3'b000, extra};

   always_comb begin
      misal = 1'b0;
      case (size_q)
         MSIZE2:  misal = addr_q[0];
         MSIZE4:  misal = (addr_q[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      size_d        = size_q;
      strb_d        = strb_q;
      wdata_d       = wdata_q;
      dresp.addr_ok = 1'b0;
      dresp.data_ok = 1'b0;
      dresp.data    = 32'h0;
      misaligned    = 1'b0;
      we            = 1'b0;

      case (state_q)
         IDLE: begin
            dresp.addr_ok = dreq.valid & resetn;
            if (dreq.valid) begin
               addr_d  = dreq.addr;
               size_d  = dreq.size;
               strb_d  = dreq.strobe;
               wdata_d = dreq.data;
               if (lat_tot == 5'd0) begin
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
                  cnt_d   = lat_tot - 5'd1;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 5'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         RESP: begin
            dresp.data_ok = 1'b1;
            if (misal) begin
               dresp.data = 32'hDEAD_BEEF;
               misaligned = 1'b1;
            end else begin
               dresp.data = mem[idx];
               we         = (strb_q != 4'b0000);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         addr_q  <= 32'h0;
         size_q  <= MSIZE1;
         strb_q  <= 4'b0000;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
      end
   end

   // Storage is deliberately not reset; lanes follow strobe with no address shift
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (strb_q[i]) begin
               mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dbus_responder.sv
// ============================================================================
// tb_dbus_responder : scoreboard bench for dbus_responder (LATENCY 1, 5 and 0)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dbus_responder;
   import dbus_pkg::*;

   logic       clk;
   logic       rstn [3];
   dbus_req_t  dreq [3];
   dbus_resp_t dresp[3];
   logic       mis  [3];

   int cyc;
   int total;
   int bad;
   int hist[8];

   typedef struct {
      int          id;
      logic [31:0] data;
      bit          chkd;
      bit          mis;
      int          acc;
      int          lmin;
      int          lmax;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dbus_responder #(
         .DEPTH_LOG2(10),
         .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 5 : 0))
      ) u_dut (
         .clk       (clk),
         .resetn    (rstn[g]),
         .dreq      (dreq[g]),
         .dresp     (dresp[g]),
         .misaligned(mis[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic int lat_of(input int id);
      return (id == 0) ? 1 : ((id == 1) ? 5 : 0);
   endfunction

   // Response monitor: every data_ok pops the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      int   d;
      for (int g = 0; g < 3; g++) begin
         if (dresp[g].data_ok) begin
            if (sb.size() == 0) begin
               check_eq("spurious_ok", 32'(dresp[g].data_ok), 32'd0);
            end else begin
               e = sb.pop_front();
               d = cyc - e.acc;
               check_eq("resp_id", 32'(g), 32'(e.id));
               if (e.chkd) check_eq("resp_data", dresp[g].data, e.data);
               check_eq("resp_mis", 32'(mis[g]), 32'(e.mis));
               check_eq("lat_ge_min", 32'(d >= e.lmin), 32'd1);
               check_eq("lat_le_max", 32'(d <= e.lmax), 32'd1);
               if (g == 2 && d >= 0 && d < 8) hist[d]++;
            end
         end else begin
            check_eq("idle_data", dresp[g].data, 32'h0);
            check_eq("idle_mis", 32'(mis[g]), 32'd0);
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge
   task automatic issue(input int id, input logic [31:0] addr, input msize_t sz,
                        input logic [3:0] strb, input logic [31:0] wd,
                        input bit chkd, input logic [31:0] ed, input bit em,
                        input bit push, output int waited, output int acc);
      exp_t e;
      int   n;
      dreq[id] = '{valid: 1'b1, addr: addr, size: sz, strobe: strb, data: wd};
      n = 0;
      @(negedge clk);
      while (!dresp[id].addr_ok && n < 64) begin
         n++;
         @(negedge clk);
      end
      waited = n;
      acc    = cyc;
      if (!dresp[id].addr_ok) begin
         check_eq("accept_timeout", 32'(dresp[id].addr_ok), 32'd1);
      end else if (push) begin
         e.id   = id;
         e.data = ed;
         e.chkd = chkd;
         e.mis  = em;
         e.acc  = cyc;
         e.lmin = lat_of(id) + 1;
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
         e.lmax = lat_of(id) + 4;
`else
         e.lmax = lat_of(id) + 1;
`endif
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      dreq[id] = '0;
   endtask

   task automatic rd(input int id, input logic [31:0] addr, input logic [31:0] ed);
      int w, a;
      issue(id, addr, MSIZE4, 4'b0000, 32'h0, 1'b1, ed, 1'b0, 1'b1, w, a);
   endtask

   task automatic wr(input int id, input logic [31:0] addr, input msize_t sz,
                     input logic [3:0] strb, input logic [31:0] wd,
                     input bit chkd, input logic [31:0] ed, input bit em);
      int w, a;
      issue(id, addr, sz, strb, wd, chkd, ed, em, 1'b1, w, a);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq("drain", 32'(sb.size()), 32'd0);
   endtask

   logic [31:0] model[8];

   initial begin
      int w0, a0, w1, a1;
      total = 0;
      bad   = 0;
      cyc   = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
      for (int g = 0; g < 3; g++) begin
         rstn[g] = 1'b0;
         dreq[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_addr_ok", 32'(dresp[0].addr_ok), 32'd0);
      check_eq("rst_data_ok", 32'(dresp[0].data_ok), 32'd0);
      check_eq("rst_data", dresp[0].data, 32'h0);
      check_eq("rst_mis", 32'(mis[0]), 32'd0);
      @(negedge clk);
      for (int g = 0; g < 3; g++) rstn[g] = 1'b1;
      @(posedge clk);
      #1;

      // LATENCY=1: basic read, same-cycle addr_ok
      wr(0, 32'h10, MSIZE4, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      drain();
      issue(0, 32'h10, MSIZE4, 4'b0000, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, w0, a0);
      check_eq("addr_ok_same_cycle", 32'(w0), 32'd0);
      drain();

      // Back-to-back write then read of the same word
      issue(0, 32'h20, MSIZE4, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b1, w0, a0);
      issue(0, 32'h20, MSIZE4, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, w1, a1);
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
      check_eq("b2b_gap_min", 32'((a1 - a0) >= 3), 32'd1);
`else
      check_eq("b2b_gap", 32'(a1 - a0), 32'd3);
`endif
      drain();

      // Byte-lane write, read-before-write data, misalignment
      wr(0, 32'h20, MSIZE4, 4'b1111, 32'h1111_1111, 1'b1, 32'hCAFE_F00D, 1'b0);
      wr(0, 32'h21, MSIZE1, 4'b0010, 32'h0000_AB00, 1'b1, 32'h1111_1111, 1'b0);
      rd(0, 32'h20, 32'h1111_AB11);
      wr(0, 32'h22, MSIZE4, 4'b1111, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b1);
      rd(0, 32'h20, 32'h1111_AB11);
      wr(0, 32'h21, MSIZE2, 4'b0011, 32'h0000_5555, 1'b1, 32'hDEAD_BEEF, 1'b1);
      wr(0, 32'h22, MSIZE2, 4'b1100, 32'hAAAA_0000, 1'b1, 32'h1111_AB11, 1'b0);
      rd(0, 32'h20, 32'hAAAA_AB11);
      rd(0, 32'h1010, 32'h1234_5678);
      rd(0, 32'h8000_0010, 32'h1234_5678);
      drain();

      // LATENCY=5: reset while BUSY drops the in-flight write
      wr(1, 32'h40, MSIZE4, 4'b1111, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0);
      drain();
      issue(1, 32'h40, MSIZE4, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0, w0, a0);
      @(posedge clk);
      #3;
      dreq[1].valid = 1'b1;
      rstn[1] = 1'b0;
      #1;
      check_eq("mid_rst_addr_ok", 32'(dresp[1].addr_ok), 32'd0);
      check_eq("mid_rst_data_ok", 32'(dresp[1].data_ok), 32'd0);
      check_eq("mid_rst_data", dresp[1].data, 32'h0);
      check_eq("mid_rst_mis", 32'(mis[1]), 32'd0);
      dreq[1] = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rstn[1] = 1'b1;
      @(posedge clk);
      #1;
      issue(1, 32'h40, MSIZE4, 4'b0000, 32'h0, 1'b1, 32'h55AA_55AA, 1'b0, 1'b1, w0, a0);
      check_eq("post_rst_accept", 32'(w0), 32'd0);
      drain();

      // LATENCY=0: preload then 64 back-to-back reads
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         wr(2, 32'(i * 4), MSIZE4, 4'b1111, model[i], 1'b0, 32'h0, 1'b0);
      end
      for (int i = 0; i < 64; i++) begin
         rd(2, 32'((i % 8) * 4), model[i % 8]);
      end
      drain();
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
      for (int k = 1; k <= 4; k++) check_eq("delay_seen", 32'(hist[k] > 0), 32'd1);
`else
      check_eq("lat0_count", 32'(hist[1]), 32'd72);
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
